// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl (+ adder4 slice)
// Brief    : WIDTH-bit add/subtract sequenced one nibble per clock through a
//            single 4-bit carry-lookahead slice, with start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

module adder4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is formed directly from generate/propagate terms.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [3:0]       w_sum4;
    logic             w_cout4;
    logic             w_accept;
    logic             w_last;

    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) & (r_count == c_last);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);

    assign w_a_shift = r_op_a >> {r_count, 2'b00};
    assign w_b_shift = r_op_b >> {r_count, 2'b00};

    adder4 u_adder4 (
        .i_a    (w_a_shift[3:0]),
        .i_b    (w_b_shift[3:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum4),
        .o_cout (w_cout4)
    );

    // Merge the current nibble result into the partial word.
    always_comb begin
        w_work_next = r_work;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_count == CNT_W'(i)) begin
                w_work_next[4*i +: 4] = w_sum4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_work   <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_count <= '0;
            r_work  <= '0;
        end else if (r_state == S_RUN) begin
            r_work  <= w_work_next;
            r_carry <= w_cout4;
            r_count <= r_count + CNT_W'(1);
            // Results publish together so they never show a partial word.
            if (w_last) begin
                sum      <= w_work_next;
                cout     <= w_cout4;
                overflow <= (r_op_a[WIDTH-1] ~^ r_op_b[WIDTH-1])
                          & (r_op_a[WIDTH-1] ^ w_sum4[3]);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    logic [31:0] h_s = '0;
    logic        h_c = 1'b0;
    logic        h_o = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic msub, input logic mcin);
        logic [31:0] bb;
        logic [32:0] r;
        logic        ov;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {32'd0, (msub ? 1'b1 : mcin)};
        ov = (ma[31] == bb[31]) && (r[31] != ma[31]);
        return {ov, r[32], r[31:0]};
    endfunction

    // Drive an operation at the next falling edge; optionally record its expected result.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic icin, input bit push,
                         input logic [31:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clock);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        if (push) begin
            e.s = es; e.c = ec; e.o = eo; e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic issue_model(input logic [31:0] ia, input logic [31:0] ib,
                               input logic isub, input logic icin);
        logic [33:0] m;
        m = model(ia, ib, isub, icin);
        issue(ia, ib, isub, icin, 1'b1, m[31:0], m[32], m[33]);
    endtask

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            h_s = '0; h_c = 1'b0; h_o = 1'b0;
        end
    end

    always @(negedge clock) begin
        exp_t it;
        if (mon_en) begin
            if (done) begin
                check("sb_has_entry", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    it = q.pop_front();
                    check("sum", 64'(sum), 64'(it.s));
                    check("cout", 64'(cout), 64'(it.c));
                    check("overflow", 64'(overflow), 64'(it.o));
                    check("latency", 64'(cyc - it.cyc), 64'd9);
                    h_s = it.s; h_c = it.c; h_o = it.o;
                end
            end else begin
                check("hold", {31'd0, overflow, cout, sum}, {31'd0, h_o, h_c, h_s});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd;
        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        check("rst_outputs", {29'd0, busy, done, overflow, cout, sum}, 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // 1) carry ripples through every nibble; busy/done widths
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        nb = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) nb++;
            if (done) nd++;
        end
        check("busy_cycles", 64'(nb), 64'd8);
        check("done_cycles", 64'(nd), 64'd1);

        // 2) signed overflow on add
        issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clock) start = 1'b0;
        repeat (10) @(negedge clock);

        // 3) subtraction with borrow, then signed overflow on subtract
        issue(32'd5, 32'd7, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge clock) start = 1'b0;
        repeat (10) @(negedge clock);
        issue(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        @(negedge clock) start = 1'b0;
        repeat (10) @(negedge clock);

        // 4) start during RUN is ignored
        issue(32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
        nd = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (i == 3) begin
                a = 32'd100; b = 32'd200; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) nd++;
        end
        check("single_done", 64'(nd), 64'd1);

        // 5) reset during RUN aborts the operation
        issue(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clock) start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_outputs", {29'd0, busy, done, overflow, cout, sum}, 64'd0);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        issue(32'd10, 32'd20, 1'b0, 1'b0, 1'b1, 32'd30, 1'b0, 1'b0);
        @(negedge clock) start = 1'b0;
        repeat (10) @(negedge clock);

        // 6) start held high: alternating pairs, then random operations
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) issue_model(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
            else            issue_model(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b1);
            repeat (8) @(negedge clock);
        end
        for (int i = 0; i < 1000; i++) begin
            issue_model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (8) @(negedge clock);
        end
        @(negedge clock) start = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        check("sb_drained", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
